// File: rtl/mult_share_arb.sv
// Round-robin arbiter that time-shares one iterative 18x18 shift-add multiplier
// between NREQ requesters, with a watchdog that aborts a stalled multiplication.
module mult_share_arb #(
  parameter int NREQ    = 4,
  parameter int W       = 18,
  parameter int TIMEOUT = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_dataa,
  input  logic [NREQ*W-1:0] req_datab,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   resp_valid,
  output logic [2*W-1:0]    resp_result,
  output logic              resp_err,
  output logic              busy,
  output logic              mul_start,
  output logic [W-1:0]      mul_dataa,
  output logic [W-1:0]      mul_datab,
  input  logic              mul_done,
  input  logic [2*W-1:0]    mul_result
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(TIMEOUT);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic [1:0]       state_q,       state_d;
  logic [IDX_W-1:0] idx_q,         idx_d;
  logic [IDX_W-1:0] rr_q,          rr_d;
  logic [CNT_W-1:0] cnt_q,         cnt_d;
  logic [NREQ-1:0]  grant_q,       grant_d;
  logic [NREQ-1:0]  resp_valid_q,  resp_valid_d;
  logic [2*W-1:0]   resp_result_q, resp_result_d;
  logic             resp_err_q,    resp_err_d;
  logic             busy_q,        busy_d;
  logic             mul_start_q,   mul_start_d;
  logic [W-1:0]     mul_dataa_q,   mul_dataa_d;
  logic [W-1:0]     mul_datab_q,   mul_datab_d;

  logic [W-1:0] opa [NREQ];
  logic [W-1:0] opb [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign opa[g] = req_dataa[g*W +: W];
    assign opb[g] = req_datab[g*W +: W];
  end

  // First requesting index at or above rr_q, wrapping around.
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;

  always_comb begin : rr_search
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    cand       = 0;
    cand_idx   = '0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(rr_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_idx = IDX_W'(cand);
      if (!pick_found && req[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    // NOTE: every _d gets a default before the case, so no path can infer a latch.
    state_d       = state_q;
    idx_d         = idx_q;
    rr_d          = rr_q;
    cnt_d         = cnt_q;
    grant_d       = '0;
    resp_valid_d  = '0;
    resp_result_d = resp_result_q;
    resp_err_d    = 1'b0;
    mul_start_d   = mul_start_q;
    mul_dataa_d   = mul_dataa_q;
    mul_datab_d   = mul_datab_q;

    case (state_q)
      ST_IDLE: begin
        mul_start_d = 1'b0;
        if (pick_found) begin
          grant_d     = NREQ'(1) << pick_idx;
          idx_d       = pick_idx;
          mul_dataa_d = opa[pick_idx];
          mul_datab_d = opb[pick_idx];
          state_d     = ST_LOAD;
        end
      end
      // Operands settle with start low so the multiplier latches them.
      ST_LOAD: begin
        mul_start_d = 1'b1;
        cnt_d       = '0;
        state_d     = ST_RUN;
      end
      ST_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (mul_done) begin
          resp_result_d = mul_result;
          resp_valid_d  = NREQ'(1) << idx_q;
          mul_start_d   = 1'b0;
          rr_d          = (idx_q == IDX_W'(NREQ - 1)) ? '0 : idx_q + 1'b1;
          state_d       = ST_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          resp_result_d = '0;
          resp_valid_d  = NREQ'(1) << idx_q;
          resp_err_d    = 1'b1;
          mul_start_d   = 1'b0;
          rr_d          = (idx_q == IDX_W'(NREQ - 1)) ? '0 : idx_q + 1'b1;
          state_d       = ST_IDLE;
        end
      end
      default: begin
        mul_start_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // NOTE: state updates use <= so every flop samples pre-edge values in parallel.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      rr_q          <= '0;
      cnt_q         <= '0;
      grant_q       <= '0;
      resp_valid_q  <= '0;
      resp_result_q <= '0;
      resp_err_q    <= 1'b0;
      busy_q        <= 1'b0;
      mul_start_q   <= 1'b0;
      mul_dataa_q   <= '0;
      mul_datab_q   <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      rr_q          <= rr_d;
      cnt_q         <= cnt_d;
      grant_q       <= grant_d;
      resp_valid_q  <= resp_valid_d;
      resp_result_q <= resp_result_d;
      resp_err_q    <= resp_err_d;
      busy_q        <= busy_d;
      mul_start_q   <= mul_start_d;
      mul_dataa_q   <= mul_dataa_d;
      mul_datab_q   <= mul_datab_d;
    end
  end

  assign grant       = grant_q;
  assign resp_valid  = resp_valid_q;
  assign resp_result = resp_result_q;
  assign resp_err    = resp_err_q;
  assign busy        = busy_q;
  assign mul_start   = mul_start_q;
  assign mul_dataa   = mul_dataa_q;
  assign mul_datab   = mul_datab_q;

endmodule

// File: tb/tb_mult_share_arb.sv
// Directed bench for mult_share_arb with a behavioural 19-edge shift-add multiplier.
module tb_mult_share_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [71:0] req_dataa;
  logic [71:0] req_datab;
  logic [3:0]  grant;
  logic [3:0]  resp_valid;
  logic [35:0] resp_result;
  logic        resp_err;
  logic        busy;
  logic        mul_start;
  logic [17:0] mul_dataa;
  logic [17:0] mul_datab;
  logic        mul_done   = 1'b0;
  logic [35:0] mul_result = '0;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mult_share_arb #(.NREQ(4), .W(18), .TIMEOUT(32)) dut (
    .CLK(clk), .RST(rst),
    .req(req), .req_dataa(req_dataa), .req_datab(req_datab),
    .grant(grant), .resp_valid(resp_valid), .resp_result(resp_result),
    .resp_err(resp_err), .busy(busy),
    .mul_start(mul_start), .mul_dataa(mul_dataa), .mul_datab(mul_datab),
    .mul_done(mul_done), .mul_result(mul_result)
  );

  // Multiplier model: latches operands while start is low, done after 19 start-high edges.
  logic [17:0] m_a = '0;
  logic [17:0] m_b = '0;
  logic [4:0]  m_cnt = '0;
  logic        stall = 1'b0;

  always @(posedge clk) begin
    if (mul_start !== 1'b1) begin
      m_cnt    <= '0;
      mul_done <= 1'b0;
      m_a      <= mul_dataa;
      m_b      <= mul_datab;
    end else if (m_cnt < 5'd19) begin
      m_cnt <= m_cnt + 5'd1;
      if (m_cnt == 5'd18 && !stall) begin
        mul_done   <= 1'b1;
        mul_result <= {18'b0, m_a} * {18'b0, m_b};
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (grant == '0 && n < 64);
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (resp_valid == '0 && n < 64);
  endtask

  task automatic set_ops(input int idx, input logic [17:0] a, input logic [17:0] b);
    req_dataa[idx*18 +: 18] = a;
    req_datab[idx*18 +: 18] = b;
  endtask

  // One isolated request: grant one cycle after req, response after exp_lat cycles.
  task automatic serve(input int idx, input logic [17:0] a, input logic [17:0] b,
                       input logic [35:0] exp_res, input logic exp_err, input int exp_lat);
    int n;
    set_ops(idx, a, b);
    req[idx] = 1'b1;
    wait_grant(n);
    check("serve_grant", 64'(grant), 64'(4'b1 << idx));
    check("serve_busy", 64'(busy), 64'(1'b1));
    req[idx] = 1'b0;
    wait_resp(n);
    check("serve_latency", 64'(n), 64'(exp_lat));
    check("serve_valid", 64'(resp_valid), 64'(4'b1 << idx));
    check("serve_result", 64'(resp_result), 64'(exp_res));
    check("serve_err", 64'(resp_err), 64'(exp_err));
  endtask

  initial begin
    int n;
    int seen;
    int exp_idx;

    rst = 1'b1; req = '0; req_dataa = '0; req_datab = '0;
    repeat (2) @(negedge clk);
    check("rst_grant", 64'(grant), 64'(0));
    check("rst_valid", 64'(resp_valid), 64'(0));
    check("rst_ctrl", 64'({resp_err, busy, mul_start}), 64'(0));
    check("rst_result", 64'(resp_result), 64'(0));
    check("rst_ops", 64'({mul_dataa, mul_datab}), 64'(0));
    rst = 1'b0;

    // Single request on requester 2: 3*5.
    serve(2, 18'd3, 18'd5, 36'd15, 1'b0, 21);
    @(negedge clk);
    check("t1_busy_after", 64'(busy), 64'(0));
    check("t1_valid_pulse", 64'(resp_valid), 64'(0));
    check("t1_result_hold", 64'(resp_result), 64'(15));

    // Fresh pointer, all four requesting: rotation 0,1,2,3,0 spaced 22 cycles.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_ops(i, 18'(i * 1000 + 7), 18'd2);
    req = 4'hF;
    for (int i = 0; i < 5; i++) begin
      exp_idx = i % 4;
      wait_grant(n);
      check("rot_gap", 64'(n), 64'(1));
      check("rot_grant", 64'(grant), 64'(4'b1 << exp_idx));
      if (i == 4) req = '0;
      wait_resp(n);
      check("rot_latency", 64'(n), 64'(21));
      check("rot_valid", 64'(resp_valid), 64'(4'b1 << exp_idx));
      check("rot_result", 64'(resp_result), 64'(2 * (exp_idx * 1000 + 7)));
    end

    // Operand extremes.
    serve(1, 18'h3FFFF, 18'h3FFFF, 36'hFFFF80001, 1'b0, 21);
    serve(1, 18'h00000, 18'h3FFFF, 36'd0, 1'b0, 21);

    // Stalled multiplier: abort after TIMEOUT run cycles, then normal service resumes.
    stall = 1'b1;
    serve(2, 18'd7, 18'd9, 36'd0, 1'b1, 33);
    @(negedge clk);
    check("wd_start_low", 64'(mul_start), 64'(0));
    check("wd_err_pulse", 64'(resp_err), 64'(0));
    stall = 1'b0;
    serve(0, 18'd100, 18'd200, 36'd20000, 1'b0, 21);

    // Reset in the middle of RUN discards the operation and resets the pointer.
    set_ops(2, 18'd11, 18'd13);
    req[2] = 1'b1;
    wait_grant(n);
    check("mr_grant", 64'(grant), 64'(4'b0100));
    req[2] = 1'b0;
    repeat (5) @(negedge clk);
    check("mr_running", 64'({busy, mul_start}), 64'(2'b11));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mr_start_drop", 64'(mul_start), 64'(0));
    check("mr_idle", 64'({busy, resp_valid, resp_err}), 64'(0));
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (resp_valid != '0 || resp_err) seen++;
    end
    check("mr_no_resp", 64'(seen), 64'(0));
    set_ops(0, 18'd21, 18'd4);
    set_ops(1, 18'd1234, 18'd567);
    req = 4'b0011;
    wait_grant(n);
    check("mr_rr_zero", 64'(grant), 64'(4'b0001));
    req[0] = 1'b0;
    wait_resp(n);
    check("mr_res0", 64'(resp_result), 64'(84));
    wait_grant(n);
    check("mr_grant1", 64'(grant), 64'(4'b0010));
    req[1] = 1'b0;
    wait_resp(n);
    check("mr_valid1", 64'(resp_valid), 64'(4'b0010));
    check("mr_res1", 64'(resp_result), 64'(699678));

    // req[0] held; req[3] arrives mid-operation and must be served before 0 again.
    set_ops(0, 18'd5, 18'd6);
    set_ops(3, 18'd9, 18'd10);
    req = 4'b0001;
    wait_grant(n);
    check("hold_grant0", 64'(grant), 64'(4'b0001));
    repeat (4) @(negedge clk);
    req[3] = 1'b1;
    wait_resp(n);
    check("hold_res0", 64'(resp_result), 64'(30));
    wait_grant(n);
    check("hold_grant3", 64'(grant), 64'(4'b1000));
    req[3] = 1'b0;
    wait_resp(n);
    check("hold_res3", 64'(resp_result), 64'(90));
    wait_grant(n);
    check("hold_grant0_again", 64'(grant), 64'(4'b0001));
    req = '0;
    wait_resp(n);
    check("hold_valid0", 64'({resp_valid, resp_err}), 64'({4'b0001, 1'b0}));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mult_share_arb.md
Name: mult_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one 18x18 iterative shift-add multiplier (`myMult18`) between NREQ chaos-map update engines.
- Accepts operand requests, captures the operands, and drives the multiplier's level-sensitive start/done protocol.
- Returns the 36-bit product to the granted requester with a one-cycle valid pulse.
- Includes a watchdog so a stalled multiplier cannot lock the shared resource.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 18, operand width; product width is 2*W.
- TIMEOUT, 32, max RUN cycles waiting for mul_done before aborting (must be > 19).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous reset, active-high.
- req  in  NREQ  per-requester request level.
- req_dataa  in  NREQ*W  packed operand A; slice i = bits [i*W +: W].
- req_datab  in  NREQ*W  packed operand B.
- grant  out  NREQ  one-hot, 1-cycle pulse; operands of that requester captured.
- resp_valid  out  NREQ  one-hot, 1-cycle pulse; resp_result valid for that requester.
- resp_result  out  2*W  product, shared by all requesters.
- resp_err  out  1  qualifies resp_valid: 1 = watchdog abort, resp_result = 0.
- busy  out  1  high in every state except IDLE.
- mul_start  out  1  to multiplier calc_start.
- mul_dataa  out  W  to multiplier dataa.
- mul_datab  out  W  to multiplier datab.
- mul_done  in  1  from multiplier done.
- mul_result  in  2*W  from multiplier result.

Behaviour:
- All outputs are registered.
- Reset values:
  - grant, resp_valid, resp_err, busy, mul_start = 0.
  - resp_result, mul_dataa, mul_datab = 0.
  - state = IDLE; rr pointer = 0 (requester 0 has highest priority first).
  - Watchdog counter = 0.
- Reset mid-operation drops mul_start the next cycle and discards the operation: no resp_valid and no error is reported.
- Multiplier contract:
  - Operands are latched while mul_start=0.
  - mul_start must stay 1 until mul_done is seen.
  - mul_start must return to 0 for at least 1 cycle between operations.
- FSM:
  - IDLE:
    - mul_start=0.
    - If req is nonzero, pick the first set bit searching from rr upward with wrap-around.
    - Pulse grant[i]; load mul_dataa/mul_datab from slice i; store the index; go to LOAD.
    - If req is zero, stay in IDLE.
  - LOAD:
    - 1 cycle, mul_start=0 so the multiplier latches the operands.
    - Next: RUN with mul_start<=1 and watchdog counter cleared.
  - RUN:
    - mul_start=1; watchdog counter increments each cycle.
    - If mul_done=1: resp_result<=mul_result, resp_valid[idx] pulse, resp_err=0, mul_start<=0, rr<=idx+1 (mod NREQ), go to IDLE.
    - Else if counter reaches TIMEOUT-1: resp_result<=0, resp_valid[idx] pulse, resp_err=1, mul_start<=0, rr<=idx+1, go to IDLE.
- Timing with the 18-bit shift-add multiplier:
  - mul_done rises after 19 edges of mul_start=1.
  - grant pulse to resp_valid pulse = 21 cycles.
  - Back-to-back grants are 22 cycles apart.
  - IDLE lasts exactly 1 cycle when req is pending, which guarantees the mul_start low gap.
- Requester rules:
  - Operands need only be valid in the cycle before grant is visible, i.e. while req is sampled in IDLE.
  - A requester may keep req high after resp_valid; that counts as a new request at lowest priority.
  - A req that drops before its grant is simply not served.
- Fairness: with all requesters requesting continuously, grants rotate 0,1,2,3,0,…
- Simultaneous events:
  - mul_done and timeout in the same cycle: done wins (resp_err=0).
  - Arrival of a new req while in LOAD/RUN: it is ignored until IDLE.
- resp_result holds its value until the next resp_valid.
- Widths:
  - Operands are unsigned.
  - resp_result is the full 2*W product; no truncation or rounding.

Test Plan:
- Reset then single req[2] with A=3, B=5 -> grant=4'b0100 pulse; resp_valid=4'b0100 exactly 21 cycles later; resp_result=15; resp_err=0; busy low 1 cycle after.
- All four req held high, operands i*1000+7 and 2 -> grants in order 0,1,2,3,0 spaced 22 cycles; each result = 2*(i*1000+7).
- Boundary operands A=B=18'h3FFFF -> resp_result=36'hFFFF80001; A=0, B=18'h3FFFF -> 0.
- Multiplier model with mul_done tied 0 -> resp_valid with resp_err=1 and resp_result=0 after TIMEOUT RUN cycles; next request still served normally.
- Assert RST for 1 cycle mid-RUN -> next cycle mul_start=0, no resp_valid, rr=0; a subsequent req[1] completes with the correct product.
- req[0] held continuously with req[3] arriving while 0 is busy -> after 0's resp_valid, grant goes to 3 before 0 again.
